// File: rtl/vga_pkg.sv
// Shared timing constants, mode encoding and the per-mode timing record.
// Every horizontal/vertical range is inclusive. Each blanking interval runs from
// its begin value to TOTAL-1, so only the begin value is stored.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_640  = 2'd0,
        MODE_800  = 2'd1,
        MODE_1024 = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    localparam int TW = 11;

    // 640x480
    localparam int M0_HTOTAL = 800;
    localparam int M0_HS_BEG = 656;
    localparam int M0_HS_END = 751;
    localparam int M0_HB_BEG = 640;
    localparam int M0_VTOTAL = 525;
    localparam int M0_VS_BEG = 490;
    localparam int M0_VS_END = 491;
    localparam int M0_VB_BEG = 480;

    // 800x600
    localparam int M1_HTOTAL = 1056;
    localparam int M1_HS_BEG = 840;
    localparam int M1_HS_END = 967;
    localparam int M1_HB_BEG = 800;
    localparam int M1_VTOTAL = 628;
    localparam int M1_VS_BEG = 601;
    localparam int M1_VS_END = 604;
    localparam int M1_VB_BEG = 600;

    // 1024x768
    localparam int M2_HTOTAL = 1344;
    localparam int M2_HS_BEG = 1048;
    localparam int M2_HS_END = 1183;
    localparam int M2_HB_BEG = 1024;
    localparam int M2_VTOTAL = 806;
    localparam int M2_VS_BEG = 771;
    localparam int M2_VS_END = 776;
    localparam int M2_VB_BEG = 768;

    typedef struct packed {
        logic [TW-1:0] htotal;
        logic [TW-1:0] hs_beg;
        logic [TW-1:0] hs_end;
        logic [TW-1:0] hb_beg;
        logic [TW-1:0] vtotal;
        logic [TW-1:0] vs_beg;
        logic [TW-1:0] vs_end;
        logic [TW-1:0] vb_beg;
    } timing_t;

    // The reserved encoding is generated as 1024x768.
    function automatic mode_t mode_clamp(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_1024 : mode_t'(m);
    endfunction

endpackage

// File: rtl/vga_if.sv
// Timing bundle: pixel/line counters plus the sync and blank flags.
// Combinational wiring only, so it adds no latency.
// There is no handshake: the source drives the bundle continuously.
interface vga_if #(
    parameter int W = 11
);
    logic [W-1:0] hcount;
    logic [W-1:0] vcount;
    logic         hsync;
    logic         hblnk;
    logic         vsync;
    logic         vblnk;

    modport src (output hcount, vcount, hsync, hblnk, vsync, vblnk);
    modport snk (input  hcount, vcount, hsync, hblnk, vsync, vblnk);
endinterface

// File: rtl/vga_mode_lut.sv
// Maps a video mode to its timing record.
// Purely combinational, with zero latency.
// There is no handshake.
// Ports: mode (in, mode_t) -> tim (out, timing_t).
module vga_mode_lut
    import vga_pkg::*;
(
    input  mode_t   mode,
    output timing_t tim
);

    always_comb begin
        tim = '{TW'(M2_HTOTAL), TW'(M2_HS_BEG), TW'(M2_HS_END), TW'(M2_HB_BEG),
                TW'(M2_VTOTAL), TW'(M2_VS_BEG), TW'(M2_VS_END), TW'(M2_VB_BEG)};
        case (mode)
            MODE_640:  tim = '{TW'(M0_HTOTAL), TW'(M0_HS_BEG), TW'(M0_HS_END), TW'(M0_HB_BEG),
                               TW'(M0_VTOTAL), TW'(M0_VS_BEG), TW'(M0_VS_END), TW'(M0_VB_BEG)};
            MODE_800:  tim = '{TW'(M1_HTOTAL), TW'(M1_HS_BEG), TW'(M1_HS_END), TW'(M1_HB_BEG),
                               TW'(M1_VTOTAL), TW'(M1_VS_BEG), TW'(M1_VS_END), TW'(M1_VB_BEG)};
            default:   ;
        endcase
    end

endmodule

// File: rtl/vga_timing_multi.sv
// Multi-mode VGA timing generator. The mode is latched only at frame boundaries.
// Counters, flags and pulses are registered together, so they are mutually aligned.
// ce gates every advance: with ce=0 all outputs hold and the pulses drop.
// Ports: clk, rst_n (async, active-low), ce, mode[1:0] in;
//        tim_out (vga_if.src), frame_start, line_start, active_mode[1:0] out.
module vga_timing_multi
    import vga_pkg::*;
#(
    parameter int         CNT_W    = 11,
    parameter logic [1:0] MODE_RST = 2'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [1:0] mode,
    vga_if.src         tim_out,
    output logic       frame_start,
    output logic       line_start,
    output logic [1:0] active_mode
);

    mode_t            mode_q;
    timing_t          tim;
    logic [CNT_W-1:0] hcount_q, vcount_q;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             hsync_q, hblnk_q, vsync_q, vblnk_q;
    logic             h_last, v_last, frame_wrap;
    logic             hs_nxt, hb_nxt, vs_nxt, vb_nxt;

    vga_mode_lut u_lut (
        .mode (mode_q),
        .tim  (tim)
    );

    always_comb begin
        h_last     = (hcount_q == CNT_W'(tim.htotal) - CNT_W'(1));
        v_last     = (vcount_q == CNT_W'(tim.vtotal) - CNT_W'(1));
        frame_wrap = h_last && v_last;
        h_nxt      = h_last ? '0 : hcount_q + CNT_W'(1);
        v_nxt      = vcount_q;
        if (h_last) begin
            v_nxt = v_last ? '0 : vcount_q + CNT_W'(1);
        end
        // Flags are decoded from the next counter values, so each flag register
        // updates together with its counter.
        // At a frame wrap the next position is (0,0). That position lies outside
        // every range in every mode, so using the outgoing mode's table is safe.
        hs_nxt = (h_nxt >= CNT_W'(tim.hs_beg)) && (h_nxt <= CNT_W'(tim.hs_end));
        hb_nxt = (h_nxt >= CNT_W'(tim.hb_beg));
        vs_nxt = (v_nxt >= CNT_W'(tim.vs_beg)) && (v_nxt <= CNT_W'(tim.vs_end));
        vb_nxt = (v_nxt >= CNT_W'(tim.vb_beg));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            hsync_q     <= 1'b0;
            hblnk_q     <= 1'b0;
            vsync_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            mode_q      <= mode_clamp(MODE_RST);
        end else begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            if (ce) begin
                hcount_q    <= h_nxt;
                vcount_q    <= v_nxt;
                hsync_q     <= hs_nxt;
                hblnk_q     <= hb_nxt;
                vsync_q     <= vs_nxt;
                vblnk_q     <= vb_nxt;
                line_start  <= h_last;
                frame_start <= frame_wrap;
                if (frame_wrap) begin
                    mode_q <= mode_clamp(mode);
                end
            end
        end
    end

    assign tim_out.hcount = hcount_q;
    assign tim_out.vcount = vcount_q;
    assign tim_out.hsync  = hsync_q;
    assign tim_out.hblnk  = hblnk_q;
    assign tim_out.vsync  = vsync_q;
    assign tim_out.vblnk  = vblnk_q;
    assign active_mode    = mode_q;

endmodule

// File: tb/tb_vga_timing_multi.sv
module tb_vga_timing_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic [1:0] mode;
    logic       frame_start, line_start;
    logic [1:0] active_mode;

    vga_if #(.W(11)) tim ();

    vga_timing_multi #(.CNT_W(11), .MODE_RST(2'd2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .mode        (mode),
        .tim_out     (tim),
        .frame_start (frame_start),
        .line_start  (line_start),
        .active_mode (active_mode)
    );

    always #5 clk = ~clk;

    // Reference timing tables, taken directly from the mode definitions.
    function automatic int ht (int m); return (m == 0) ? 800  : (m == 1) ? 1056 : 1344; endfunction
    function automatic int hs0(int m); return (m == 0) ? 656  : (m == 1) ? 840  : 1048; endfunction
    function automatic int hs1(int m); return (m == 0) ? 751  : (m == 1) ? 967  : 1183; endfunction
    function automatic int hb0(int m); return (m == 0) ? 640  : (m == 1) ? 800  : 1024; endfunction
    function automatic int vt (int m); return (m == 0) ? 525  : (m == 1) ? 628  : 806;  endfunction
    function automatic int vs0(int m); return (m == 0) ? 490  : (m == 1) ? 601  : 771;  endfunction
    function automatic int vs1(int m); return (m == 0) ? 491  : (m == 1) ? 604  : 776;  endfunction
    function automatic int vb0(int m); return (m == 0) ? 480  : (m == 1) ? 600  : 768;  endfunction

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, hb, vs, vb, fs, ls;
        logic [1:0]  am;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ls_prev = -1;
    int   ls_last = -1;

    // The model tracks a linear pixel index within the frame. h and v are derived
    // from that index by division, not by chained counters.
    int   pix = 0;
    int   am_m = 2;

    function automatic obs_t model_obs(int m, int p, bit fs, bit ls);
        obs_t o;
        int   h, v;
        h    = p % ht(m);
        v    = p / ht(m);
        o.h  = 11'(h);
        o.v  = 11'(v);
        o.hs = (h >= hs0(m)) && (h <= hs1(m));
        o.hb = (h >= hb0(m));
        o.vs = (v >= vs0(m)) && (v <= vs1(m));
        o.vb = (v >= vb0(m));
        o.fs = fs;
        o.ls = ls;
        o.am = 2'(m);
        return o;
    endfunction

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // Drive one clock's inputs and queue what the DUT must show after that edge.
    task automatic step(input bit c, input logic [1:0] m);
        bit fs, ls;
        @(negedge clk);
        ce   = c;
        mode = m;
        if (c) begin
            pix = (pix + 1) % (ht(am_m) * vt(am_m));
            if (pix == 0) am_m = (m == 2'd3) ? 2 : int'(m);
        end
        fs = c && (pix == 0);
        ls = c && ((pix % ht(am_m)) == 0);
        exp_q.push_back(model_obs(am_m, pix, fs, ls));
    endtask

    // Fast-forward: place the DUT at an arbitrary raster position so that frame
    // boundaries can be reached without running whole frames.
    logic [10:0] j_h, j_v;
    logic        j_hs, j_hb, j_vs, j_vb;

    task automatic jump(input int h, input int v);
        obs_t o;
        @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
        pix  = v * ht(am_m) + h;
        o    = model_obs(am_m, pix, 1'b0, 1'b0);
        j_h  = o.h;  j_v  = o.v;
        j_hs = o.hs; j_hb = o.hb; j_vs = o.vs; j_vb = o.vb;
        force dut.hcount_q = j_h;
        force dut.vcount_q = j_v;
        force dut.hsync_q  = j_hs;
        force dut.hblnk_q  = j_hb;
        force dut.vsync_q  = j_vs;
        force dut.vblnk_q  = j_vb;
        #1;
        release dut.hcount_q;
        release dut.vcount_q;
        release dut.hsync_q;
        release dut.hblnk_q;
        release dut.vsync_q;
        release dut.vblnk_q;
    endtask

    task automatic drain();
        @(negedge clk);
        ce = 1'b0;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs never presented, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_hcount"}, int'(tim.hcount), 0);
        chk({nm, "_vcount"}, int'(tim.vcount), 0);
        chk({nm, "_flags"}, int'({tim.hsync, tim.hblnk, tim.vsync, tim.vblnk, frame_start, line_start}), 0);
        chk({nm, "_active_mode"}, int'(active_mode), 2);
    endtask

    // Monitor: pops the expected record for each edge the driver accounted for.
    obs_t mon_e, mon_a;
    always @(posedge clk) begin
        cyc++;
        #1;
        if (line_start) begin
            ls_prev = ls_last;
            ls_last = cyc;
        end
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{tim.hcount, tim.vcount, tim.hsync, tim.hblnk, tim.vsync, tim.vblnk,
                      frame_start, line_start, active_mode};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d got h=%0d v=%0d hs%0d hb%0d vs%0d vb%0d fs%0d ls%0d am%0d required h=%0d v=%0d hs%0d hb%0d vs%0d vb%0d fs%0d ls%0d am%0d",
                         cyc, mon_a.h, mon_a.v, mon_a.hs, mon_a.hb, mon_a.vs, mon_a.vb, mon_a.fs, mon_a.ls, mon_a.am,
                         mon_e.h, mon_e.v, mon_e.hs, mon_e.hb, mon_e.vs, mon_e.vb, mon_e.fs, mon_e.ls, mon_e.am);
            end
        end
    end

    // Range and pulse consistency for whichever mode is active.
    a_hblnk: assert property (@(posedge clk) disable iff (!rst_n)
        tim.hblnk == (int'(tim.hcount) >= hb0(int'(active_mode))))
        else begin errors++; $display("FAIL assert_hblnk h=%0d hblnk=%0d", tim.hcount, tim.hblnk); end
    a_vblnk: assert property (@(posedge clk) disable iff (!rst_n)
        tim.vblnk == (int'(tim.vcount) >= vb0(int'(active_mode))))
        else begin errors++; $display("FAIL assert_vblnk v=%0d vblnk=%0d", tim.vcount, tim.vblnk); end
    a_hsync: assert property (@(posedge clk) disable iff (!rst_n)
        tim.hsync == (int'(tim.hcount) >= hs0(int'(active_mode)) && int'(tim.hcount) <= hs1(int'(active_mode))))
        else begin errors++; $display("FAIL assert_hsync h=%0d hsync=%0d", tim.hcount, tim.hsync); end
    a_vsync: assert property (@(posedge clk) disable iff (!rst_n)
        tim.vsync == (int'(tim.vcount) >= vs0(int'(active_mode)) && int'(tim.vcount) <= vs1(int'(active_mode))))
        else begin errors++; $display("FAIL assert_vsync v=%0d vsync=%0d", tim.vcount, tim.vsync); end
    a_fs_once: assert property (@(posedge clk) disable iff (!rst_n) frame_start |=> !frame_start)
        else begin errors++; $display("FAIL assert_frame_start_width frame_start=1 required 0"); end
    a_fs_pos: assert property (@(posedge clk) disable iff (!rst_n)
        frame_start |-> (tim.hcount == 0 && tim.vcount == 0 && line_start))
        else begin errors++; $display("FAIL assert_frame_start_pos h=%0d v=%0d", tim.hcount, tim.vcount); end
    a_bounds: assert property (@(posedge clk) disable iff (!rst_n)
        int'(tim.hcount) < ht(int'(active_mode)) && int'(tim.vcount) < vt(int'(active_mode)))
        else begin errors++; $display("FAIL assert_bounds h=%0d v=%0d am=%0d", tim.hcount, tim.vcount, active_mode); end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        mode  = 2'd2;
        repeat (3) @(negedge clk);
        #1 chk_zero("reset");
        rst_n = 1'b1;
        pix = 0; am_m = 2;

        // Idle cycles hold. The first enabled edge then gives hcount=1 with no frame_start.
        repeat (3) step(1'b0, 2'd2);
        repeat (2000) step(1'b1, 2'd2);

        // Mode 2 vsync onset, vsync end, then the frame wrap.
        jump(1330, 770); repeat (1500) step(1'b1, 2'd2);
        jump(1330, 776); repeat (100)  step(1'b1, 2'd2);
        jump(1330, 805); repeat (100)  step(1'b1, 2'd2);

        // Request mode 0 mid-frame. It takes effect only at the next frame.
        jump(0, 100);    repeat (200)  step(1'b1, 2'd0);
        jump(1300, 805); repeat (1750) step(1'b1, 2'd0);

        // The mode toggles before the boundary; only the value at the wrap (3 -> 2) applies.
        jump(780, 524);
        for (int i = 0; i < 1500; i++) step(1'b1, (i < 12) ? 2'($urandom) : 2'd3);
        chk("mode3_as_mode2", int'(active_mode), 2);

        // Mode 1 with ce alternating: a line must span 2112 clocks.
        jump(1330, 805);
        for (int i = 0; i < 4300; i++) step(i % 2 == 0, 2'd1);
        drain();
        chk("mode1_active", int'(active_mode), 1);
        chk("mode1_ce_half_line_clks", ls_last - ls_prev, 2112);

        // Asynchronous reset mid-frame at (500,300).
        jump(500, 300);
        repeat (5) step(1'b1, 2'd1);
        drain();
        chk("pre_reset_hcount", int'(tim.hcount), 505);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(negedge clk);
        chk_zero("held_reset");
        rst_n = 1'b1;
        pix = 0; am_m = 2;
        repeat (50) step(1'b1, 2'd1);

        // Random ce and random mode across several frame boundaries.
        for (int r = 0; r < 6; r++) begin
            jump(ht(am_m) - 20, vt(am_m) - 1);
            repeat (1500) step($urandom_range(0, 3) != 0, 2'($urandom));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
